// File: rtl/probe_capture_pkg.sv
// Shared constants, channel-index width helper and sample entry layout for probe_capture.
// Defining PROBE_CAPTURE_TIMESTAMP_EN adds the timestamp field to the entry.
package probe_capture_pkg;

  localparam int unsigned TS_W       = 16;
  localparam int unsigned MAX_CHAN_W = 4;
  localparam int unsigned MAX_DATA_W = 64;

  // Channel index width, never narrower than one bit.
  function automatic int unsigned chan_w(input int unsigned channels);
    if (channels <= 1) return 32'd1;
    return $clog2(channels);
  endfunction

  // Widest-case entry; instances store the same field order trimmed to their own widths.
  typedef struct packed {
    logic [MAX_CHAN_W-1:0] chan;
    logic [MAX_DATA_W-1:0] data;
`ifdef PROBE_CAPTURE_TIMESTAMP_EN
    logic [TS_W-1:0]       ts;
`endif
  } probe_entry_t;

endpackage

// File: rtl/probe_fifo.sv
// Synchronous FIFO holding probe samples; accepts a push while full when a pop happens
// in the same cycle. The head entry is presented combinationally from storage.
module probe_fifo
  import probe_capture_pkg::*;
#(
  parameter int unsigned ENTRY_W = 8,
  parameter int unsigned DEPTH   = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [ENTRY_W-1:0]         push_data,
  input  logic                       pop,
  output logic [ENTRY_W-1:0]         head,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr_ptr;
  logic               do_push;
  logic               do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Storage carries no reset; only entries behind a valid count are ever observed.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/probe_capture.sv
// Multi-channel change-capture probe: change detect, shadow/pending slots, round-robin
// arbitration into a sample FIFO, saturating drop counter. PROBE_CAPTURE_TIMESTAMP_EN adds O_ts.
module probe_capture
  import probe_capture_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned DROP_W   = 8
) (
  input  logic                        CLK,
  input  logic                        ASYNCRESET,
  input  logic [CHANNELS*WIDTH-1:0]   I,
  input  logic [CHANNELS-1:0]         en,
  output logic                        O_valid,
  input  logic                        O_ready,
  output logic [WIDTH-1:0]            O_data,
  output logic [chan_w(CHANNELS)-1:0] O_chan,
`ifdef PROBE_CAPTURE_TIMESTAMP_EN
  output logic [TS_W-1:0]             O_ts,
`endif
  output logic [DROP_W-1:0]           drops
);

  localparam int unsigned CW    = chan_w(CHANNELS);
  localparam int unsigned NDW   = $clog2(CHANNELS + 1);
  localparam int unsigned SUM_W = DROP_W + NDW;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
`ifdef PROBE_CAPTURE_TIMESTAMP_EN
  localparam int unsigned TS_BITS = TS_W;
`else
  localparam int unsigned TS_BITS = 0;
`endif
  localparam int unsigned ENTRY_W = CW + WIDTH + TS_BITS;
  localparam logic [DROP_W-1:0] DROP_MAX = '1;

  logic [WIDTH-1:0]    prev   [CHANNELS];
  logic [WIDTH-1:0]    shadow [CHANNELS];
  logic [CHANNELS-1:0] pend;
  logic [CHANNELS-1:0] chg;
  logic [CHANNELS-1:0] drop;
  logic [CW-1:0]       last_gnt;
  logic [CW-1:0]       gnt_idx;
  logic                gnt_valid;
  logic                pop;
  logic                can_push;
  logic [NDW-1:0]      n_drops;
  logic [SUM_W-1:0]    drop_sum;
  logic [ENTRY_W-1:0]  push_entry;
  logic [ENTRY_W-1:0]  head;
  logic [CNT_W-1:0]    fifo_count;
  logic                fifo_full;
  logic                fifo_empty;
`ifdef PROBE_CAPTURE_TIMESTAMP_EN
  logic [TS_W-1:0]     ts;
  logic [TS_W-1:0]     shadow_ts [CHANNELS];
`endif

  assign pop      = O_valid && O_ready;
  assign can_push = !fifo_full || pop;

  always_comb begin
    chg = '0;
    for (int k = 0; k < int'(CHANNELS); k++)
      chg[k] = en[k] && (I[k*WIDTH +: WIDTH] != prev[k]);
  end

  // Round-robin: walk from the highest offset down so the channel right after last_gnt wins.
  always_comb begin
    int unsigned idx;
    idx       = 0;
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    for (int i = int'(CHANNELS); i > 0; i--) begin
      idx = (32'(last_gnt) + 32'(i)) % CHANNELS;
      if (can_push && pend[CW'(idx)]) begin
        gnt_valid = 1'b1;
        gnt_idx   = CW'(idx);
      end
    end
  end

  // A change landing on a slot that is still occupied and not leaving this cycle is a drop.
  always_comb begin
    drop    = '0;
    n_drops = '0;
    for (int k = 0; k < int'(CHANNELS); k++) begin
      drop[k] = chg[k] && pend[k] && !(gnt_valid && gnt_idx == CW'(k));
      n_drops = n_drops + NDW'(drop[k]);
    end
  end

  assign drop_sum = SUM_W'(drops) + SUM_W'(n_drops);

`ifdef PROBE_CAPTURE_TIMESTAMP_EN
  assign push_entry = {gnt_idx, shadow[gnt_idx], shadow_ts[gnt_idx]};
`else
  assign push_entry = {gnt_idx, shadow[gnt_idx]};
`endif

  always_ff @(posedge CLK or posedge ASYNCRESET) begin
    if (ASYNCRESET) begin
      for (int k = 0; k < int'(CHANNELS); k++) begin
        prev[k]   <= '0;
        shadow[k] <= '0;
`ifdef PROBE_CAPTURE_TIMESTAMP_EN
        shadow_ts[k] <= '0;
`endif
      end
      pend     <= '0;
      last_gnt <= CW'(CHANNELS - 1);
      drops    <= '0;
`ifdef PROBE_CAPTURE_TIMESTAMP_EN
      ts       <= '0;
`endif
    end else begin
      for (int k = 0; k < int'(CHANNELS); k++) begin
        prev[k] <= I[k*WIDTH +: WIDTH];
        if (chg[k]) begin
          shadow[k] <= I[k*WIDTH +: WIDTH];
          pend[k]   <= 1'b1;
`ifdef PROBE_CAPTURE_TIMESTAMP_EN
          shadow_ts[k] <= ts;
`endif
        end else if (gnt_valid && gnt_idx == CW'(k)) begin
          pend[k] <= 1'b0;
        end
      end
      if (gnt_valid) last_gnt <= gnt_idx;
      if (n_drops != '0)
        drops <= (drop_sum > SUM_W'(DROP_MAX)) ? DROP_MAX : DROP_W'(drop_sum);
`ifdef PROBE_CAPTURE_TIMESTAMP_EN
      ts <= ts + 1'b1;
`endif
    end
  end

  probe_fifo #(
    .ENTRY_W (ENTRY_W),
    .DEPTH   (DEPTH)
  ) u_fifo (
    .clk       (CLK),
    .rst       (ASYNCRESET),
    .push      (gnt_valid),
    .push_data (push_entry),
    .pop       (pop),
    .head      (head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign O_valid = (fifo_count != '0);
  assign O_data  = fifo_empty ? '0 : head[TS_BITS +: WIDTH];
  assign O_chan  = fifo_empty ? '0 : head[TS_BITS + WIDTH +: CW];
`ifdef PROBE_CAPTURE_TIMESTAMP_EN
  assign O_ts    = fifo_empty ? '0 : head[TS_W-1:0];
`endif

endmodule

// File: doc/probe_capture.md
# probe_capture

Parametrised, clocked successor to the single-bit bind-wire tap. Observes `CHANNELS` internal signals of `WIDTH` bits each, routed in by cross-module bind. Each value change on an enabled channel is recorded as a tagged sample in an internal FIFO. Samples are drained through a valid/ready port, and a saturating drop counter records every change lost to back-pressure. The block is instantiated next to the probed module and terminates the bound nets, so the probed datapath is never loaded or altered.

## Interface
Parameters:
- `WIDTH`, 8: bits per probed channel; 1 to 64.
- `CHANNELS`, 4: number of probed channels; 1 to 16.
- `DEPTH`, 8: FIFO entries; power of two, 2 to 64.
- `DROP_W`, 8: width of the drop counter.

Ports (`CW` = max(1, clog2(`CHANNELS`))):
- `CLK`  in  1  clock; all state updates on the rising edge.
- `ASYNCRESET`  in  1  reset; asynchronous, active-high.
- `I`  in  `CHANNELS*WIDTH`  probed values; channel k is `I[k*WIDTH +: WIDTH]`.
- `en`  in  `CHANNELS`  per-channel capture enable.
- `O_valid`  out  1  FIFO head holds a sample.
- `O_ready`  in  1  consumer accepts the head.
- `O_data`  out  `WIDTH`  head sample value.
- `O_chan`  out  `CW`  head sample channel index.
- `drops`  out  `DROP_W`  count of lost changes; saturates at all-ones.

## Operation
- Per channel k:
  - `prev[k]` registers `I[k]` every cycle.
  - A change is `I[k] != prev[k]` while `en[k]` = 1.
- On a change, `shadow[k]` takes the new value and `pend[k]` is set.
- If `pend[k]` is already set and not being granted that cycle:
  - `shadow[k]` is overwritten with the newest value.
  - `drops` increments by 1.
- Each cycle, a round-robin arbiter grants one pending channel, provided the FIFO can accept a push.
  - The search starts at the index after the last grant.
  - On reset, the pointer is set so that channel 0 has highest priority.
- The granted `{k, shadow[k]}` is pushed and `pend[k]` is cleared.
  - A change on the granted channel in the same cycle re-sets `pend[k]` with the new value. This is not a drop.
- The FIFO can accept a push when count < `DEPTH`, or when count = `DEPTH` and a pop happens in the same cycle.
- A pop occurs when `O_valid` && `O_ready`.
- When the FIFO is empty, `O_data` and `O_chan` are forced to 0.
- Disabling `en[k]` does not clear `pend[k]`; an already pending sample is still delivered.
- If several changes in one cycle each qualify as a drop, `drops` adds 1 per channel that drops.
- `drops` saturates and never wraps.

## Timing
- Reset values:
  - `O_valid`, `O_data`, `O_chan`, `drops` are 0.
  - All `prev`, `shadow`, `pend`, FIFO pointers and count are 0.
- Because `prev` resets to 0, a nonzero `I[k]` in the first cycle after reset is captured.
- Latency: a change sampled at edge t sets `pend` at t. It is granted in cycle t..t+1 and pushed at edge t+1. `O_valid` rises after edge t+1, giving a minimum of 2 edges from input change to visible sample.
- Throughput: one push and one pop per cycle.
- Reset mid-operation immediately discards all FIFO contents and pending samples, and clears `drops`.
- Handshake: while `O_valid` = 1 and `O_ready` = 0, `O_data` and `O_chan` hold stable.

## Configuration
- `PROBE_CAPTURE_TIMESTAMP_EN` defined:
  - Adds a free-running 16-bit `ts` counter, reset to 0, that wraps.
  - Each FIFO entry also stores the `ts` value from the cycle the change was detected.
  - Adds output `O_ts  out  16`, which reads 0 when the FIFO is empty.
- `PROBE_CAPTURE_TIMESTAMP_EN` undefined: no counter, no `O_ts` port, and entries hold only `{chan, data}`.

## Structure
- Package `probe_capture_pkg` holds:
  - the `CW` computation function;
  - the entry struct typedef `{chan, data[, ts]}`;
  - the `TS_W` = 16 constant.
- Sub-module `probe_fifo` is a synchronous FIFO:
  - parameterised on entry width and `DEPTH`;
  - supports simultaneous push/pop when full;
  - outputs `count`, `full`, `empty`.
- The top level contains change detect, shadow/pending registers, the round-robin arbiter and the drop counter.

## Test plan
- Reset release with `I` = 0x00 and all `en` = 1; ch1 goes to 0x5A at cycle 3 with `O_ready` = 1 → exactly one sample {chan 1, data 0x5A}; `O_valid` high 2 edges after the change; `drops` = 0.
- ch0, ch2 and ch3 all change in the same cycle → samples emerge in order chan 0, 2, 3 on consecutive cycles; next grant search starts at chan 0.
- `O_ready` = 0; ch0 toggles 0x01, 0x02, … for 12 cycles with `DEPTH` = 8 → FIFO full with the first 8 values, `pend[0]` holds the latest value, `drops` = 3; raising `O_ready` drains 9 samples.
- FIFO full and `O_ready` = 1 while a change is pending → the push is accepted in the same cycle; count stays at 8; no drop.
- `en[2]` = 0 and ch2 toggles → no sample and `drops` unchanged; `ASYNCRESET` pulsed mid-drain → `O_valid` drops immediately and all outputs are 0.
- With `PROBE_CAPTURE_TIMESTAMP_EN`: changes at `ts` 5 and 9 → `O_ts` reads 5 then 9; wrap from 0xFFFF to 0x0000 is checked.
